// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: PC/pipeline-register enables, flushes and bubbles
// for load-use, taken-branch and multi-cycle memory hazards, plus debug counters.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk_ctrl,
  input  logic             rst_ctrl,
  input  logic             mem_req_in,
  input  logic             mem_ack,
  input  logic             ld_use_hazard,
  input  logic             branch_taken,
  output logic             PC_en,
  output logic             en_IFID,
  output logic             en_IDEX,
  output logic             en_EXMem,
  output logic             en_MemWB,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             bubble_MemWB,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t           r_state, w_next;
  logic [7:0]       r_wait_cnt, w_wait_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_mem_stall;

  // RUN and MEM_WAIT share one output rule: an unacked request freezes the front end.
  assign w_mem_stall = mem_req_in & ~mem_ack;

  always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
    if (rst_ctrl) begin
      r_state    <= RUN;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  always_comb begin
    PC_en        = 1'b0;
    en_IFID      = 1'b0;
    en_IDEX      = 1'b0;
    en_EXMem     = 1'b0;
    en_MemWB     = 1'b0;
    flush_IFID   = 1'b0;
    flush_IDEX   = 1'b0;
    bubble_MemWB = 1'b0;
    w_next       = r_state;
    w_wait_nxt   = r_wait_cnt;
    case (r_state)
      RUN, MEM_WAIT: begin
        if (w_mem_stall) begin
          en_MemWB     = 1'b1;
          bubble_MemWB = 1'b1;
          if (r_state == RUN) begin
            w_next     = MEM_WAIT;
            w_wait_nxt = 8'd1;
          end else if (r_wait_cnt == 8'(MEM_TIMEOUT)) begin
            w_next = ERROR;
          end else begin
            w_wait_nxt = r_wait_cnt + 8'd1;
          end
        end else begin
          PC_en    = 1'b1;
          en_IFID  = 1'b1;
          en_IDEX  = 1'b1;
          en_EXMem = 1'b1;
          en_MemWB = 1'b1;
          // A taken branch makes the load-use instruction wrong-path, so it wins.
          if (branch_taken) begin
            flush_IFID = 1'b1;
            flush_IDEX = 1'b1;
          end else if (ld_use_hazard) begin
            PC_en      = 1'b0;
            en_IFID    = 1'b0;
            flush_IDEX = 1'b1;
          end
          w_next     = RUN;
          w_wait_nxt = 8'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_ctrl or posedge rst_ctrl) begin
    if (rst_ctrl) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (r_state != ERROR) begin
      if (!PC_en && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush_IFID && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign mem_err   = (r_state == ERROR);
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage RISC-V CPU. It drives the enable and bubble controls of the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.
- It resolves three hazards:
  - load-use hazards reported by decode,
  - taken branches/jumps reported by EX,
  - multi-cycle data-memory accesses, via a request/acknowledge wait state machine with timeout.
- It keeps saturating stall and flush counters for debug.

## Interface
- MEM_TIMEOUT, 15: maximum number of consecutive MEM_WAIT cycles without `mem_ack` before entering ERROR. Legal range is 1..255.
- CNT_W, 16: width of the performance counters.

Ports:
- clk_ctrl  in  1  clock, rising edge.
- rst_ctrl  in  1  reset, asynchronous, active-high.
- mem_req_in  in  1  instruction in MEM stage is a load or store (MemRead|MemWrite of EX/MEM).
- mem_ack  in  1  data memory has completed the current MEM-stage access this cycle.
- ld_use_hazard  in  1  decode detected that an ID source register matches an ID/EX load destination.
- branch_taken  in  1  EX-stage branch/jump redirects the PC.
- PC_en  out  1  PC register enable.
- en_IFID, en_IDEX, en_EXMem, en_MemWB  out  1 each  pipeline register enables.
- flush_IFID, flush_IDEX  out  1 each  load a bubble (NOP, all control 0) on the next edge.
- bubble_MemWB  out  1  top level forces RegWrite_in/MemtoReg_in of MEM/WB to 0 this cycle.
- mem_err  out  1  sticky memory-timeout error.
- stall_cnt  out  CNT_W  cycles with PC_en=0 outside ERROR, saturating.
- flush_cnt  out  CNT_W  cycles with branch flush applied, saturating.

## Operation
- FSM states: RUN, MEM_WAIT, ERROR. The state and an 8-bit `wait_cnt` are registered. All enable, flush and bubble outputs are combinational from state and inputs.
- Hazard priority: memory stall > branch > load-use.
- **RUN, mem_req_in=1 and mem_ack=0**
  - All of PC_en, en_IFID, en_IDEX, en_EXMem are 0. No flushes.
  - en_MemWB=1 and bubble_MemWB=1, so WB drains and a bubble enters MEM/WB.
  - Next state MEM_WAIT; wait_cnt<=1.
- **RUN otherwise**: all enables 1, bubble_MemWB=0, with the following modifiers.
  - branch_taken=1: flush_IFID=1 and flush_IDEX=1. ld_use_hazard is ignored because that instruction is wrong-path.
  - ld_use_hazard=1 (no branch): PC_en=0, en_IFID=0, flush_IDEX=1.
  - mem_ack in RUN without mem_req_in is ignored.
- **MEM_WAIT, mem_ack=1, or mem_req_in=0 (defensive)**
  - Outputs are identical to RUN with the same inputs, so the pipeline advances.
  - branch_taken and ld_use_hazard are acted on in this cycle because EX and ID were frozen and their inputs held.
  - Next state RUN.
- **MEM_WAIT, mem_ack=0**
  - Outputs are as for the RUN stall case.
  - If wait_cnt==MEM_TIMEOUT, next state is ERROR; otherwise wait_cnt<=wait_cnt+1.
- **ERROR**
  - All enables 0 and all flushes 0.
  - mem_err=1.
  - Counters freeze.
  - Exit is by reset only.
- **Counters**
  - stall_cnt increments on every edge where PC_en=0 and state!=ERROR.
  - flush_cnt increments on every edge where flush_IFID=1.
  - Both hold at 2^CNT_W-1 (no wrap).

## Timing
- Reset, asynchronous: state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0.
- With all inputs 0 after reset: PC_en and all en_*=1; flushes and bubble are 0.
- Reset asserted mid-MEM_WAIT or in ERROR returns to RUN immediately, without waiting for a clock edge.
- A single-cycle memory (mem_ack in the same cycle as mem_req_in) causes zero stall cycles.
- Memory stall: the request cycle plus N MEM_WAIT cycles gives N+1 stall cycles, with release in the cycle mem_ack=1.
- Load-use: exactly 1 stall cycle per assertion cycle. The input normally deasserts once the bubble reaches EX.
- Branch: 2 instructions flushed, in the same cycle branch_taken is seen (outside a memory stall).
- Timeout: ERROR is entered after MEM_TIMEOUT MEM_WAIT cycles without ack, i.e. MEM_TIMEOUT+1 stall cycles after the request.
- mem_err asserts in the first ERROR cycle.
- No output depends combinationally on the counters.

## Test plan
- Reset then idle 5 cycles -> PC_en=en_*=1, flushes=0, mem_err=0, stall_cnt=0, flush_cnt=0.
- Load-use pulse of 1 cycle -> that cycle: PC_en=0, en_IFID=0, flush_IDEX=1, en_EXMem=en_MemWB=1; stall_cnt=1 afterwards.
- mem_req_in=1 with mem_ack arriving 3 cycles later -> 3 cycles of frozen PC/IFID/IDEX/EXMem with bubble_MemWB=1; release in the ack cycle; stall_cnt=3.
- branch_taken and ld_use_hazard both 1 in RUN -> flush_IFID=flush_IDEX=1, PC_en=1; flush_cnt=1, stall_cnt unchanged.
- branch_taken=1 held during a 2-cycle memory stall -> no flush during the stall; flush_IFID=flush_IDEX=1 only in the mem_ack cycle; flush_cnt=1.
- MEM_TIMEOUT=4, mem_req_in=1 with no ack -> stall for 5 cycles, then mem_err=1 and all enables 0; assert rst_ctrl mid-cycle -> immediate RUN with mem_err=0 and counters 0.
